// File: rtl/alu32_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Holds the ALU operands in registers and returns tagged results on one response channel.
//
// state | meaning
// IDLE  | waiting for a request; grant decided combinationally
// EXEC  | ALU driven from latched operands for one cycle
// RESP  | response held on rsp_* until rsp_ready
module alu32_arbiter #(
    parameter int DATA_W = 32,
    parameter int CODE_W = 4,
    parameter int RR_EN  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [CODE_W-1:0] req0_code,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [CODE_W-1:0] req1_code,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [CODE_W-1:0] alu_code,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_v,
    input  logic              alu_n,
    input  logic              alu_z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_v,
    output logic              rsp_n,
    output logic              rsp_z,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [CODE_W-1:0] CODE_NOP = CODE_W'(4'b1111);

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
    logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
    logic [CODE_W-1:0]   alu_code_q, alu_code_d;
    logic                id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_v_q, rsp_v_d;
    logic                rsp_n_q, rsp_n_d;
    logic                rsp_z_q, rsp_z_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;

    logic                grant_id;
    logic                accept;
    logic                code_legal;

    // On a tie, round-robin favours whoever was not served last.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = (RR_EN != 0) ? ~last_grant_q : 1'b0;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state_q == IDLE) && req1_valid && grant_id;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        code_legal = 1'b0;
        case (alu_code_q)
            CODE_W'(4'b0000), CODE_W'(4'b0001), CODE_W'(4'b0010),
            CODE_W'(4'b0110), CODE_W'(4'b0111), CODE_W'(4'b1001),
            CODE_W'(4'b1100), CODE_W'(4'b1101), CODE_W'(4'b1111):
                code_legal = 1'b1;
            default:
                code_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_code_d   = alu_code_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_v_d      = rsp_v_q;
        rsp_n_d      = rsp_n_q;
        rsp_z_d      = rsp_z_q;
        rsp_err_d    = rsp_err_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_op1_d  = grant_id ? req1_op1  : req0_op1;
                    alu_op2_d  = grant_id ? req1_op2  : req0_op2;
                    alu_code_d = grant_id ? req1_code : req0_code;
                    id_d       = grant_id;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_err_d   = 1'b0;
                // NOP leaves the previous result and flags on the response bus.
                if (alu_code_q == CODE_NOP) begin
                    rsp_result_d = rsp_result_q;
                end else if (code_legal) begin
                    rsp_result_d = alu_result;
                    rsp_v_d      = alu_v;
                    rsp_n_d      = alu_n;
                    rsp_z_d      = alu_z;
                end else begin
                    rsp_result_d = '0;
                    rsp_v_d      = 1'b0;
                    rsp_n_d      = 1'b0;
                    rsp_z_d      = 1'b0;
                    rsp_err_d    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    if (!rsp_id_q) begin
                        if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
                    end else begin
                        if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_code_q   <= CODE_NOP;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_v_q      <= 1'b0;
            rsp_n_q      <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_code_q   <= alu_code_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_v_q      <= rsp_v_d;
            rsp_n_q      <= rsp_n_d;
            rsp_z_q      <= rsp_z_d;
            rsp_err_q    <= rsp_err_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_code   = alu_code_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_v      = rsp_v_q;
    assign rsp_n      = rsp_n_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter with a behavioural ALU attached to the ALU port.
module tb_alu32_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_op1, req0_op2;
    logic [3:0]  req0_code;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_op1, req1_op2;
    logic [3:0]  req1_code;
    logic [31:0] alu_op1, alu_op2;
    logic [3:0]  alu_code;
    logic [31:0] alu_result;
    logic        alu_v, alu_n, alu_z;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_v, rsp_n, rsp_z, rsp_err;
    logic        busy;
    logic [15:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu32_arbiter #(.DATA_W(32), .CODE_W(4), .RR_EN(1), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_code(req0_code),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_code(req1_code),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_code(alu_code),
        .alu_result(alu_result), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_v(rsp_v), .rsp_n(rsp_n), .rsp_z(rsp_z),
        .rsp_err(rsp_err), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    // NOP and illegal codes produce distinctive garbage so hold/zeroing is observable.
    always_comb begin
        alu_v = 1'b0;
        case (alu_code)
            4'b0000: alu_result = alu_op1 & alu_op2;
            4'b0001: alu_result = alu_op1 | alu_op2;
            4'b0010: begin
                alu_result = alu_op1 + alu_op2;
                alu_v = (alu_op1[31] == alu_op2[31]) && (alu_result[31] != alu_op1[31]);
            end
            4'b0110: begin
                alu_result = alu_op1 - alu_op2;
                alu_v = (alu_op1[31] != alu_op2[31]) && (alu_result[31] != alu_op1[31]);
            end
            4'b0111: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
            4'b1001: alu_result = ~(alu_op1 | alu_op2);
            4'b1100: alu_result = ~(alu_op1 & alu_op2);
            4'b1101: alu_result = alu_op1 ^ alu_op2;
            4'b1111: alu_result = 32'h1234_5678;
            default: begin
                alu_result = 32'hDEAD_BEEF;
                alu_v = 1'b1;
            end
        endcase
        alu_n = alu_result[31];
        alu_z = (alu_result == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req0_valid = v; req0_op1 = a; req0_op2 = b; req0_code = c;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req1_valid = v; req1_op1 = a; req1_op2 = b; req1_code = c;
    endtask

    initial begin
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        set_req0(1'b0, 32'd0, 32'd0, 4'b0000);
        set_req1(1'b0, 32'd0, 32'd0, 4'b0000);
        tick();
        tick();

        // Reset state
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_code", alu_code, 32'hF);
        check("rst_alu_op1", alu_op1, 0);
        check("rst_alu_op2", alu_op2, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);

        // Single ADD from requester 0
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        set_req0(1'b1, 32'd5, 32'd7, 4'b0010);
        #1;
        check("add_req0_ready", req0_ready, 1);
        check("add_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("add_exec_busy", busy, 1);
        check("add_exec_op1", alu_op1, 5);
        check("add_exec_op2", alu_op2, 7);
        check("add_exec_code", alu_code, 32'h2);
        check("add_exec_rsp_valid", rsp_valid, 0);
        tick();
        check("add_rsp_valid", rsp_valid, 1);
        check("add_rsp_result", rsp_result, 12);
        check("add_rsp_id", rsp_id, 0);
        check("add_rsp_z", rsp_z, 0);
        check("add_rsp_n", rsp_n, 0);
        check("add_rsp_err", rsp_err, 0);
        tick();
        check("add_done_valid", rsp_valid, 0);
        check("add_done_busy", busy, 0);
        check("add_done_cnt0", cnt0, 1);
        check("add_done_cnt1", cnt1, 0);

        // Round-robin with both requesters always valid, starting from reset
        reset_n = 1'b0;
        tick();
        check("rr_rst_cnt0", cnt0, 0);
        reset_n = 1'b1;
        set_req0(1'b1, 32'd3, 32'd3, 4'b0110);
        set_req1(1'b1, 32'd2, 32'd9, 4'b0111);
        #1;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = (i % 2) != 0;
            check($sformatf("rr%0d_ready0", i), req0_ready, !g);
            check($sformatf("rr%0d_ready1", i), req1_ready, g);
            tick();
            tick();
            check($sformatf("rr%0d_rsp_valid", i), rsp_valid, 1);
            check($sformatf("rr%0d_rsp_id", i), rsp_id, g);
            check($sformatf("rr%0d_rsp_result", i), rsp_result, g ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_rsp_z", i), rsp_z, g ? 32'd0 : 32'd1);
            tick();
        end
        check("rr_cnt0", cnt0, 2);
        check("rr_cnt1", cnt1, 2);

        // Back-pressure: response held for 5 cycles with rsp_ready low
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        set_req1(1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000);
        #1;
        check("bp_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        set_req0(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0010);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
            check($sformatf("bp%0d_rsp_result", i), rsp_result, 32'h0000_F000);
            check($sformatf("bp%0d_rsp_id", i), rsp_id, 1);
            check($sformatf("bp%0d_ready0", i), req0_ready, 0);
            check($sformatf("bp%0d_ready1", i), req1_ready, 0);
            check($sformatf("bp%0d_busy", i), busy, 1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release_busy", busy, 0);
        check("bp_release_valid", rsp_valid, 0);
        check("bp_release_cnt1", cnt1, 3);

        // Signed overflow ADD followed by NOP
        check("ovf_req0_ready", req0_ready, 1);
        tick();
        set_req0(1'b1, 32'd1, 32'd1, 4'b1111);
        tick();
        check("ovf_rsp_result", rsp_result, 32'h8000_0000);
        check("ovf_rsp_n", rsp_n, 1);
        check("ovf_rsp_v", rsp_v, 1);
        check("ovf_rsp_z", rsp_z, 0);
        check("ovf_rsp_id", rsp_id, 0);
        tick();
        check("nop_req0_ready", req0_ready, 1);
        tick();
        check("nop_exec_code", alu_code, 32'hF);
        tick();
        check("nop_rsp_valid", rsp_valid, 1);
        check("nop_rsp_result", rsp_result, 32'h8000_0000);
        check("nop_rsp_n", rsp_n, 1);
        check("nop_rsp_v", rsp_v, 1);
        check("nop_rsp_z", rsp_z, 0);
        check("nop_rsp_err", rsp_err, 0);

        // Illegal code
        set_req0(1'b1, 32'd9, 32'd4, 4'b0011);
        tick();
        check("ill_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        check("ill_rsp_valid", rsp_valid, 1);
        check("ill_rsp_result", rsp_result, 0);
        check("ill_rsp_v", rsp_v, 0);
        check("ill_rsp_n", rsp_n, 0);
        check("ill_rsp_z", rsp_z, 0);
        check("ill_rsp_err", rsp_err, 1);
        tick();
        check("ill_cnt0", cnt0, 5);

        // Reset during EXEC aborts the operation and restores tie priority to req0
        set_req0(1'b1, 32'd6, 32'd3, 4'b0000);
        set_req1(1'b1, 32'd6, 32'd3, 4'b0001);
        #1;
        check("abort_req1_ready", req1_ready, 1);
        tick();
        check("abort_exec_busy", busy, 1);
        reset_n = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_cnt0", cnt0, 0);
        check("abort_cnt1", cnt1, 0);
        check("abort_alu_code", alu_code, 32'hF);
        reset_n = 1'b1;
        #1;
        check("abort_tie_ready0", req0_ready, 1);
        check("abort_tie_ready1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        check("abort_no_rsp", rsp_valid, 0);
        check("abort_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
